i2c_slave_stretch: RTL and testbench
====================================

Name: i2c_slave_stretch

Overview:
Parametrised next-generation I2C slave bridging an external I2C bus to an internal register file. It supports 1-4 register-address bytes and 1-4 data bytes per word, plus an address match mask. Reads use a request/acknowledge handshake with SCL clock stretching, and input glitch filtering is configurable. It sits between the pad open-drain buffers and the register bank.

Parameters:
ADDR_BYTES, 1, register-address bytes after the chip address (1-4)
DATA_BYTES, 2, bytes per register word (1-4)
REG_ADDR_WIDTH, 8*ADDR_BYTES, reg_addr width
REG_DATA_WIDTH, 8*DATA_BYTES, register word width
FILTER_LEN, 3, consecutive equal synchronised samples needed to accept an SDA/SCL level change (1-15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
open_drain  in  1  1: sda_out/scl_out tied 0, drive via oen; 0: push-pull on sda_out, oen=0
sda_in  in  1  SDA pad input
sda_out  out  1  SDA output value
sda_oen  out  1  SDA output enable, 1 = released
scl_in  in  1  SCL pad input
scl_out  out  1  SCL output value (constant 0)
scl_oen  out  1  SCL output enable, 0 = hold SCL low (stretch)
chip_addr  in  7  slave address
addr_mask  in  7  1 bits are don't-care in the address compare
reg_addr  out  REG_ADDR_WIDTH  current register address
wr_en  out  1  one-cycle write strobe
wr_data  out  REG_DATA_WIDTH  write word, valid with wr_en
rd_req  out  1  read request, held until rd_ack
rd_ack  in  1  rd_data valid this cycle
rd_data  in  REG_DATA_WIDTH  read word
busy  out  1  transaction in progress (START to STOP/abort)
done  out  1  one-cycle pulse at end of an addressed transaction
nack_err  out  1  sticky; set when the master NACKs before a word boundary; cleared at START

Behaviour:
- Reset (reset=0 at posedge clk): state IDLE; sda_oen=1, scl_oen=1, sda_out=open_drain?0:1, scl_out=0; wr_en=0, rd_req=0, busy=0, done=0, nack_err=0; reg_addr=0, wr_data=0. Reset mid-transfer releases both lines in the same cycle.
- Input path: 2-flop synchroniser, then FILTER_LEN filter. Edge detection runs on filtered levels. Event latency is 2+FILTER_LEN clk.
- START is a filtered SDA fall while SCL is high, from any state. It enters ADDR, sets busy=1, clears the byte counters and nack_err, and keeps reg_addr. A repeated START behaves identically.
- STOP is a filtered SDA rise while SCL is high. It enters IDLE and releases lines. done pulses if the chip address matched in this transaction.
- States: IDLE, ADDR, ACK, RX, WRITE, RDREQ, TX, CHK_ACK.
- ADDR: shift 8 bits on SCL rising edges, MSB first. Match when ((byte[7:1] ^ chip_addr) & ~addr_mask)==0. On no match, go to IDLE without ACK; busy drops and done is not pulsed.
- ACK: after the SCL fall following bit 8, drive SDA low. Release at the next SCL fall. Then:
  - R=1 (address byte) -> RDREQ.
  - Otherwise -> RX.
- RX:
  - The first ADDR_BYTES bytes build reg_addr, MSB first. reg_addr updates after the final address byte.
  - Then data bytes accumulate MSB first. After byte DATA_BYTES, go to WRITE, then ACK.
  - A STOP or START before a word completes discards the partial word; no wr_en.
  - A START/STOP arriving in the same cycle as the last bit completes the event, not the write.
- WRITE: wr_en=1 for exactly one clk with wr_data valid; then reg_addr+1 (wraps modulo 2^REG_ADDR_WIDTH).
- RDREQ: entered with SCL low. Assert scl_oen=0 and rd_req=1. On rd_ack, latch rd_data, drop rd_req, release scl_oen the next clk, then go to TX. rd_ack with rd_req=0 is ignored.
- TX: present the next MSB on each SCL fall, with the first bit present before SCL release. After 8 bits go to CHK_ACK.
- CHK_ACK: sample SDA on SCL rise.
  - ACK at a word boundary -> reg_addr+1, then RDREQ.
  - ACK mid-word -> TX on the next byte.
  - NACK -> IDLE and done pulse; set nack_err if mid-word.
- Counters: byte counter is 3 bits and bit counter is 3 bits. No overflow is possible because widths are bounded by the parameters.

Optional Feature:
I2C_SLAVE_TIMEOUT_EN: adds a 20-bit counter of consecutive clk with filtered SCL low while busy. At 2^20-1, force IDLE, release both lines, drop rd_req, and pulse done; nack_err is unaffected. Without the macro there is no counter, and a stuck SCL holds the state indefinitely.

Test Plan:
1. chip_addr=0x50, mask=0, ADDR_BYTES=1, DATA_BYTES=2. Write 0xA0,0x10,0x12,0x34,0x56,0x78,STOP -> wr_en pulses twice (0x10:0x1234, 0x11:0x5678); 6 ACKs; done pulses once.
2. Write pointer 0x20, repeated START, read 0xA1. rd_ack delayed 50 clk, rd_data=0xBEEF -> SCL held low ≥50 clk; bytes 0xBE,0xEF; master NACK -> done, nack_err=0.
3. Master NACKs after the first read byte -> IDLE, nack_err=1, done pulses; the next START clears nack_err.
4. Address 0x51 with mask=0x01 -> ACK. Address 0x52 with mask=0x01 -> no ACK, busy falls, no done.
5. Write 0x10,0x12, then STOP mid-word -> no wr_en. Glitch of FILTER_LEN-1 clk on SDA while SCL high -> no START/STOP detected.
6. reset low mid-TX and during stretch -> next clk sda_oen=1, scl_oen=1, rd_req=0, state IDLE.

Source files
------------

// File: rtl/i2c_slave_stretch.sv
// I2C slave bridging an external bus to a register file, with read-side SCL stretching.
// Define I2C_SLAVE_TIMEOUT_EN to abort a transaction after 2^20-1 clk of SCL held low.
module i2c_slave_stretch #(
    parameter int unsigned ADDR_BYTES     = 1,
    parameter int unsigned DATA_BYTES     = 2,
    parameter int unsigned REG_ADDR_WIDTH = 8 * ADDR_BYTES,
    parameter int unsigned REG_DATA_WIDTH = 8 * DATA_BYTES,
    parameter int unsigned FILTER_LEN     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      open_drain,
    input  logic                      sda_in,
    output logic                      sda_out,
    output logic                      sda_oen,
    input  logic                      scl_in,
    output logic                      scl_out,
    output logic                      scl_oen,
    input  logic [6:0]                chip_addr,
    input  logic [6:0]                addr_mask,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic                      wr_en,
    output logic [REG_DATA_WIDTH-1:0] wr_data,
    output logic                      rd_req,
    input  logic                      rd_ack,
    input  logic [REG_DATA_WIDTH-1:0] rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      nack_err
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAck, StRx, StWrite, StRdReq, StTx, StChkAck
    } state_e;

    // Index 0 is SDA, index 1 is SCL.
    logic [1:0]      sync1_q, sync2_q, filt_q, flip;
    logic [1:0][3:0] fcnt_q;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            flip[i] = (sync2_q[i] != filt_q[i]) && (fcnt_q[i] == 4'(FILTER_LEN - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            fcnt_q  <= '0;
        end else begin
            sync1_q <= {scl_in, sda_in};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i] || flip[i]) begin
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 4'd1;
                end
                if (flip[i]) begin
                    filt_q[i] <= sync2_q[i];
                end
            end
        end
    end

    logic sda_f, scl_f, start_evt, stop_evt, scl_rise, scl_fall;
    assign sda_f     = filt_q[0];
    assign scl_f     = filt_q[1];
    assign start_evt = flip[0] && sda_f && scl_f;
    assign stop_evt  = flip[0] && !sda_f && scl_f;
    assign scl_rise  = flip[1] && !scl_f;
    assign scl_fall  = flip[1] && scl_f;

    state_e                    state_q, state_d;
    logic [6:0]                shift_q, shift_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d, byte_cnt_q, byte_cnt_d;
    logic [REG_DATA_WIDTH-1:0] word_q, word_d;
    logic [REG_ADDR_WIDTH-1:0] ptr_q, ptr_d, reg_addr_q, reg_addr_d;
    logic                      rw_q, rw_d, matched_q, matched_d, addr_done_q, addr_done_d;
    logic                      phase_q, phase_d, nack_err_q, nack_err_d, done_q, done_d;
    logic [7:0]                rx_byte;
    logic                      timeout;

`ifdef I2C_SLAVE_TIMEOUT_EN
    logic [19:0] to_cnt_q;
    assign timeout = &to_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset || !busy || scl_f) begin
            to_cnt_q <= '0;
        end else if (!timeout) begin
            to_cnt_q <= to_cnt_q + 20'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign rx_byte = {shift_q, sda_f};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        ptr_d       = ptr_q;
        reg_addr_d  = reg_addr_q;
        rw_d        = rw_q;
        matched_d   = matched_q;
        addr_done_d = addr_done_q;
        phase_d     = phase_q;
        nack_err_d  = nack_err_q;
        done_d      = 1'b0;
        if (start_evt) begin
            state_d     = StAddr;
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
            nack_err_d  = 1'b0;
            matched_d   = 1'b0;
            addr_done_d = 1'b0;
            phase_d     = 1'b0;
        end else if (stop_evt) begin
            state_d   = StIdle;
            done_d    = matched_q;
            matched_d = 1'b0;
            phase_d   = 1'b0;
        end else if (timeout) begin
            state_d   = StIdle;
            done_d    = 1'b1;
            matched_d = 1'b0;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            if (((rx_byte[7:1] ^ chip_addr) & ~addr_mask) == 7'd0) begin
                                state_d   = StAck;
                                rw_d      = rx_byte[0];
                                matched_d = 1'b1;
                                phase_d   = 1'b0;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                // phase 0: wait for the fall ending bit 8; phase 1: SDA held low.
                StAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = '0;
                            if (rw_q) begin
                                state_d    = StRdReq;
                                byte_cnt_d = '0;
                            end else begin
                                state_d = StRx;
                            end
                        end
                    end
                end
                StRx: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            if (!addr_done_q) begin
                                ptr_d   = (ptr_q << 8) | REG_ADDR_WIDTH'(rx_byte);
                                state_d = StAck;
                                if (byte_cnt_q == 3'(ADDR_BYTES - 1)) begin
                                    reg_addr_d  = ptr_d;
                                    addr_done_d = 1'b1;
                                    byte_cnt_d  = '0;
                                end else begin
                                    byte_cnt_d = byte_cnt_q + 3'd1;
                                end
                            end else begin
                                word_d = (word_q << 8) | REG_DATA_WIDTH'(rx_byte);
                                if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
                                    byte_cnt_d = '0;
                                    state_d    = StWrite;
                                end else begin
                                    byte_cnt_d = byte_cnt_q + 3'd1;
                                    state_d    = StAck;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                StWrite: begin
                    reg_addr_d = reg_addr_q + 1'b1;
                    state_d    = StAck;
                    phase_d    = 1'b0;
                end
                // phase 1: word latched, first bit on SDA while SCL is still held.
                StRdReq: begin
                    if (!phase_q) begin
                        if (rd_ack) begin
                            word_d  = rd_data;
                            phase_d = 1'b1;
                        end
                    end else begin
                        phase_d   = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = StTx;
                    end
                end
                StTx: begin
                    if (scl_fall) begin
                        word_d = word_q << 1;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            state_d   = StChkAck;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                // ACK is sampled on the rise but acted on at the fall, so SDA only moves with SCL low.
                StChkAck: begin
                    if (!phase_q) begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                phase_d = 1'b1;
                            end else begin
                                state_d   = StIdle;
                                done_d    = 1'b1;
                                matched_d = 1'b0;
                                if (byte_cnt_q != 3'(DATA_BYTES - 1)) begin
                                    nack_err_d = 1'b1;
                                end
                            end
                        end
                    end else if (scl_fall) begin
                        phase_d = 1'b0;
                        if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
                            byte_cnt_d = '0;
                            reg_addr_d = reg_addr_q + 1'b1;
                            state_d    = StRdReq;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            state_d    = StTx;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            ptr_q       <= '0;
            reg_addr_q  <= '0;
            rw_q        <= 1'b0;
            matched_q   <= 1'b0;
            addr_done_q <= 1'b0;
            phase_q     <= 1'b0;
            nack_err_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            ptr_q       <= ptr_d;
            reg_addr_q  <= reg_addr_d;
            rw_q        <= rw_d;
            matched_q   <= matched_d;
            addr_done_q <= addr_done_d;
            phase_q     <= phase_d;
            nack_err_q  <= nack_err_d;
            done_q      <= done_d;
        end
    end

    logic sda_low;
    always_comb begin
        sda_low = 1'b0;
        case (state_q)
            StAck:   sda_low = phase_q;
            StRdReq: sda_low = phase_q && !word_q[REG_DATA_WIDTH-1];
            StTx:    sda_low = !word_q[REG_DATA_WIDTH-1];
            default: sda_low = 1'b0;
        endcase
    end

    assign sda_out  = open_drain ? 1'b0 : !sda_low;
    assign sda_oen  = open_drain ? !sda_low : 1'b0;
    assign scl_out  = 1'b0;
    assign scl_oen  = (state_q != StRdReq);
    assign rd_req   = (state_q == StRdReq) && !phase_q;
    assign wr_en    = (state_q == StWrite);
    assign wr_data  = word_q;
    assign reg_addr = reg_addr_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign nack_err = nack_err_q;

endmodule

// File: tb/tb_i2c_slave_stretch.sv
// Scoreboard bench for i2c_slave_stretch: bit-level I2C master, register-bank responder,
// expected writes and read bytes queued at stimulus time and compared as the DUT produces them.
module tb_i2c_slave_stretch;

    localparam int FILTER_LEN = 3;
    localparam int TH         = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        sda_m, scl_m;
    logic        sda_out, sda_oen, scl_out, scl_oen;
    logic        sda_bus, scl_bus;
    logic [6:0]  chip_addr, addr_mask;
    logic [7:0]  reg_addr;
    logic        wr_en, rd_req, rd_ack, busy, done, nack_err;
    logic [15:0] wr_data, rd_data;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int stretch_run = 0;
    int last_stretch = 0;
    int rd_delay = 3;
    int rd_n = 0;

    logic [23:0] wr_exp_q[$];
    logic [7:0]  rd_exp_q[$];

    always #5 clk = ~clk;

    assign sda_bus = sda_m & (sda_oen ? 1'b1 : sda_out);
    assign scl_bus = scl_m & (scl_oen ? 1'b1 : scl_out);

    i2c_slave_stretch #(
        .ADDR_BYTES(1),
        .DATA_BYTES(2),
        .FILTER_LEN(FILTER_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .open_drain(1'b1),
        .sda_in    (sda_bus),
        .sda_out   (sda_out),
        .sda_oen   (sda_oen),
        .scl_in    (scl_bus),
        .scl_out   (scl_out),
        .scl_oen   (scl_oen),
        .chip_addr (chip_addr),
        .addr_mask (addr_mask),
        .reg_addr  (reg_addr),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .nack_err  (nack_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: writes, done pulses, stretch length.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (wr_en) begin
                wr_cnt++;
                check("wr_expected", 32'(wr_exp_q.size() != 0), 32'd1);
                if (wr_exp_q.size() != 0) begin
                    e = wr_exp_q.pop_front();
                    check("wr_addr", 32'(reg_addr), 32'(e[23:16]));
                    check("wr_data", 32'(wr_data), 32'(e[15:0]));
                end
            end
            if (!scl_oen) begin
                stretch_run++;
            end else if (stretch_run > 0) begin
                last_stretch = stretch_run;
                stretch_run  = 0;
            end
        end
    end

    // Register-bank responder; expected read bytes are queued when the word is handed over.
    initial begin
        rd_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_ack = 1'b0;
            if (rd_req && rd_n >= rd_delay) begin
                rd_ack = 1'b1;
                rd_exp_q.push_back(rd_data[15:8]);
                rd_exp_q.push_back(rd_data[7:0]);
                rd_n = 0;
            end else if (rd_req) begin
                rd_n++;
            end else begin
                rd_n = 0;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_scl_high();
        for (int i = 0; i < 5000; i++) begin
            if (scl_bus) break;
            @(posedge clk);
            #1;
        end
        check("scl_release", 32'(scl_bus), 32'd1);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;
        wait_clks(TH);
        scl_m = 1'b1;
        wait_scl_high();
        wait_clks(TH);
        scl_m = 1'b0;
        wait_clks(TH);
    endtask

    task automatic read_bit(output logic v);
        sda_m = 1'b1;
        wait_clks(TH);
        scl_m = 1'b1;
        wait_scl_high();
        wait_clks(TH / 2);
        v = sda_bus;
        wait_clks(TH / 2);
        scl_m = 1'b0;
        wait_clks(TH);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clks(TH);
        scl_m = 1'b1;
        wait_scl_high();
        wait_clks(TH);
        sda_m = 1'b0;
        wait_clks(TH);
        scl_m = 1'b0;
        wait_clks(TH);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clks(TH);
        scl_m = 1'b1;
        wait_scl_high();
        wait_clks(TH);
        sda_m = 1'b1;
        wait_clks(TH);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(v);
        ack = !v;
    endtask

    task automatic read_byte(input logic ack, input string tag);
        logic [7:0] b;
        logic       v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            b[i] = v;
        end
        write_bit(!ack);
        check({tag, "_avail"}, 32'(rd_exp_q.size() != 0), 32'd1);
        if (rd_exp_q.size() != 0) check(tag, 32'(b), 32'(rd_exp_q.pop_front()));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        wait_clks(1);
        check("rst_sda_oen", 32'(sda_oen), 32'd1);
        check("rst_scl_oen", 32'(scl_oen), 32'd1);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        sda_m = 1'b1;
        wait_clks(TH);
        scl_m = 1'b1;
        wait_clks(4 * TH);
    endtask

    initial begin
        logic ack;
        int   acks, d0, w0;
        reset     = 1'b0;
        sda_m     = 1'b1;
        scl_m     = 1'b1;
        chip_addr = 7'h50;
        addr_mask = 7'h00;
        rd_data   = 16'h0000;
        wait_clks(4);
        check("reset_sda_oen", 32'(sda_oen), 32'd1);
        check("reset_scl_oen", 32'(scl_oen), 32'd1);
        check("reset_sda_out", 32'(sda_out), 32'd0);
        check("reset_scl_out", 32'(scl_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd_req", 32'(rd_req), 32'd0);
        check("reset_nack_err", 32'(nack_err), 32'd0);
        check("reset_reg_addr", 32'(reg_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b1;
        wait_clks(4 * TH);

        // 1: two-word write with auto-increment
        d0 = done_cnt;
        w0 = wr_cnt;
        acks = 0;
        i2c_start();
        check("t1_busy", 32'(busy), 32'd1);
        write_byte(8'hA0, ack); acks += int'(ack);
        write_byte(8'h10, ack); acks += int'(ack);
        wr_exp_q.push_back({8'h10, 16'h1234});
        write_byte(8'h12, ack); acks += int'(ack);
        write_byte(8'h34, ack); acks += int'(ack);
        wr_exp_q.push_back({8'h11, 16'h5678});
        write_byte(8'h56, ack); acks += int'(ack);
        write_byte(8'h78, ack); acks += int'(ack);
        i2c_stop();
        wait_clks(2 * TH);
        check("t1_acks", 32'(acks), 32'd6);
        check("t1_wr_cnt", 32'(wr_cnt - w0), 32'd2);
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_wr_left", 32'(wr_exp_q.size()), 32'd0);
        check("t1_reg_addr", 32'(reg_addr), 32'h12);
        check("t1_busy_end", 32'(busy), 32'd0);

        // 2: pointer write, repeated START, stretched read
        d0 = done_cnt;
        rd_delay = 50;
        rd_data  = 16'hBEEF;
        rd_exp_q.delete();
        i2c_start();
        write_byte(8'hA0, ack);
        check("t2_ack_addr", 32'(ack), 32'd1);
        write_byte(8'h20, ack);
        check("t2_ack_ptr", 32'(ack), 32'd1);
        i2c_start();
        write_byte(8'hA1, ack);
        check("t2_ack_rd", 32'(ack), 32'd1);
        read_byte(1'b1, "t2_byte0");
        check("t2_stretch", 32'(last_stretch >= 50), 32'd1);
        read_byte(1'b0, "t2_byte1");
        i2c_stop();
        wait_clks(2 * TH);
        check("t2_done", 32'(done_cnt - d0), 32'd1);
        check("t2_nack_err", 32'(nack_err), 32'd0);
        check("t2_reg_addr", 32'(reg_addr), 32'h20);

        // 3: NACK mid-word sets nack_err; next START clears it
        d0 = done_cnt;
        rd_delay = 3;
        rd_data  = 16'hCAFE;
        rd_exp_q.delete();
        i2c_start();
        write_byte(8'hA1, ack);
        read_byte(1'b0, "t3_byte0");
        wait_clks(4);
        check("t3_nack_err", 32'(nack_err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        i2c_stop();
        check("t3_done", 32'(done_cnt - d0), 32'd1);
        rd_exp_q.delete();
        i2c_start();
        check("t3_nack_clr", 32'(nack_err), 32'd0);
        i2c_stop();
        wait_clks(2 * TH);

        // 4: address mask
        addr_mask = 7'h01;
        d0 = done_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        check("t4_ack_51", 32'(ack), 32'd1);
        i2c_stop();
        wait_clks(2 * TH);
        check("t4_done_51", 32'(done_cnt - d0), 32'd1);
        d0 = done_cnt;
        i2c_start();
        write_byte(8'hA4, ack);
        check("t4_ack_52", 32'(ack), 32'd0);
        check("t4_busy_52", 32'(busy), 32'd0);
        i2c_stop();
        wait_clks(2 * TH);
        check("t4_done_52", 32'(done_cnt - d0), 32'd0);
        addr_mask = 7'h00;

        // 5: partial word discarded; short glitches ignored
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h10, ack);
        write_byte(8'h12, ack);
        i2c_stop();
        wait_clks(2 * TH);
        check("t5_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("t5_reg_addr", 32'(reg_addr), 32'h10);
        sda_m = 1'b0;
        wait_clks(FILTER_LEN - 1);
        sda_m = 1'b1;
        wait_clks(2 * TH);
        check("t5_glitch_start", 32'(busy), 32'd0);
        i2c_start();
        write_byte(8'hA0, ack);
        sda_m = 1'b0;
        wait_clks(TH);
        scl_m = 1'b1;
        wait_clks(TH);
        sda_m = 1'b1;
        wait_clks(FILTER_LEN - 1);
        sda_m = 1'b0;
        wait_clks(TH);
        check("t5_glitch_stop", 32'(busy), 32'd1);
        scl_m = 1'b0;
        wait_clks(TH);
        i2c_stop();
        wait_clks(2 * TH);
        check("t5_no_wr2", 32'(wr_cnt - w0), 32'd0);

        // 6: reset mid-TX and during stretch
        rd_delay = 3;
        rd_exp_q.delete();
        i2c_start();
        write_byte(8'hA1, ack);
        for (int i = 0; i < 3; i++) read_bit(ack);
        check("t6_tx_busy", 32'(busy), 32'd1);
        pulse_reset();
        rd_exp_q.delete();
        rd_delay = 300;
        i2c_start();
        write_byte(8'hA1, ack);
        wait_clks(10);
        check("t6_stretch_scl", 32'(scl_oen), 32'd0);
        check("t6_stretch_req", 32'(rd_req), 32'd1);
        pulse_reset();
        rd_delay = 3;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
